router_uart_ni_gen: RTL and testbench
=====================================

ROUTER_UART_NI_GEN -- requirements
Module: router_uart_ni_gen

Interface
REQ-001 SHALL have parameter FLIT_W, default 16, flit width in bits; a multiple of 8, at least 16.
REQ-002 SHALL have parameter MAX_FLITS, default 4, maximum flits per packet including head and tail; range 2..16.
REQ-003 SHALL have parameter BAUD_DIV, default 16, clk cycles per UART bit; at least 2.
REQ-004 SHALL have parameter SEQ_W, default 8, sequence-number width; at most FLIT_W-3.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-007 SHALL have port flit_in, input, FLIT_W, incoming router flit.
REQ-008 SHALL have port flit_valid, input, 1, flit_in is valid this cycle.
REQ-009 SHALL have port flit_ready, output, 1, the block accepts flit_in this cycle.
REQ-010 SHALL have port txd, output, 1, UART serial output (8N1, LSB first).
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-012 SHALL have port seq_err, output, 1, one-cycle pulse when a head is rejected for sequence mismatch.
REQ-013 SHALL have port frame_err, output, 1, one-cycle pulse when an in-progress packet is aborted.
REQ-014 SHALL have ports reg_seq and pri_seq, output, SEQ_W each, the next expected regular and priority sequence numbers.

Function
REQ-015 SHALL accept a flit on a cycle where flit_valid and flit_ready are both high; no other flit is accepted or stored.
REQ-016 SHALL decode flit type from flit_in[FLIT_W-1:FLIT_W-3]: 000 regular head, 001 priority head, 010 body, 110 tail, any other code is invalid; head sequence field is flit_in[SEQ_W-1:0].
REQ-017 SHALL implement states IDLE, COLLECT and SEND; flit_ready is high in IDLE and COLLECT and low in SEND.
REQ-018 SHALL, in IDLE, on an accepted head whose sequence field equals reg_seq (type 000) or pri_seq (type 001):
  - store the head as flit 0 and set the flit count to 1;
  - increment the matching sequence counter modulo 2^SEQ_W, with the other counter unchanged;
  - enter COLLECT.
REQ-019 SHALL, in IDLE, on an accepted head with a mismatched sequence, discard it, pulse seq_err and stay in IDLE.
REQ-020 SHALL, in IDLE, silently discard accepted body, tail and invalid flits.
REQ-021 SHALL, in COLLECT, on an accepted body flit:
  - when count < MAX_FLITS-1, store it and increment count;
  - otherwise discard the packet, pulse frame_err and return to IDLE.
REQ-022 SHALL, in COLLECT, on an accepted tail, store it, increment count and enter SEND.
REQ-023 SHALL, in COLLECT, on an accepted head or invalid flit, discard the packet and the flit, pulse frame_err, leave both sequence counters unchanged and return to IDLE.
REQ-024 SHALL, in SEND, transmit the stored flits in arrival order.
  - Within each flit, bytes go most-significant first.
  - Each byte is framed as start bit 0, 8 data bits LSB first, stop bit 1.
  - Every bit is held exactly BAUD_DIV cycles, with no gap between bytes.
REQ-025 SHALL drive txd low (first start bit) in the first cycle after the tail-accept cycle.
REQ-026 SHALL return to IDLE count*(FLIT_W/8)*10*BAUD_DIV cycles after txd first goes low; txd is 1 at that point.
REQ-027 SHALL hold txd at 1 in IDLE and COLLECT.
REQ-028 SHALL drive seq_err and frame_err low except on the single cycle following their triggering accept.

Reset
REQ-029 SHALL, while rst is high at a clock edge, set the following regardless of current state, including mid-SEND:
  - state IDLE, txd=1, busy=0, flit_ready=0;
  - seq_err=0, frame_err=0;
  - reg_seq=0, pri_seq=0, flit count 0, baud and bit counters 0.
REQ-030 SHALL raise flit_ready the first cycle after rst deasserts.

Verification
REQ-031 SHALL pass: defaults, head 0x0000 then tail 0xC0A5 -> bytes 0x00,0x00,0xC0,0xA5 on txd; busy high for 640 cycles of SEND; reg_seq=1.
REQ-032 SHALL pass: priority head 0x2000, body 0x4123, tail 0xC0FF -> 6 bytes 0x20,0x00,0x41,0x23,0xC0,0xFF in 960 cycles; pri_seq=1; reg_seq unchanged.
REQ-033 SHALL pass: head 0x0005 with reg_seq=0 -> seq_err one-cycle pulse; txd stays 1; reg_seq stays 0.
REQ-034 SHALL pass: head 0x0000 then bodies 0x4001, 0x4002, 0x4003 -> frame_err pulse on the third body; IDLE; no txd activity; reg_seq=1.
REQ-035 SHALL pass: reg_seq at 0xFF, head 0x00FF then tail -> packet sent; reg_seq wraps to 0x00.
REQ-036 SHALL pass: rst high for one cycle 100 cycles into SEND -> next cycle txd=1, busy=0, both sequences 0; a following head 0x0000 is accepted.

Source files
------------

// File: rtl/router_uart_ni_gen.sv
// Router-to-UART network interface.
// Collects a head/body/tail flit packet, checks the head's sequence number
// against a regular or a priority counter, then streams the stored flits
// out of an 8N1 UART. Bytes go most-significant first and bits LSB first.
module router_uart_ni_gen #(
  parameter int FLIT_W    = 16,
  parameter int MAX_FLITS = 4,
  parameter int BAUD_DIV  = 16,
  parameter int SEQ_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_valid,
  output logic              flit_ready,
  output logic              txd,
  output logic              busy,
  output logic              seq_err,
  output logic              frame_err,
  output logic [SEQ_W-1:0]  reg_seq,
  output logic [SEQ_W-1:0]  pri_seq
);

  localparam int IW    = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
  localparam int CW    = IW + 1;
  localparam int BYTES = FLIT_W / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int BDW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [2:0] T_REG  = 3'b000;
  localparam logic [2:0] T_PRI  = 3'b001;
  localparam logic [2:0] T_BODY = 3'b010;
  localparam logic [2:0] T_TAIL = 3'b110;

  typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_t;

  state_t             state;
  logic               rdy;
  logic [CW-1:0]      count;
  logic [IW-1:0]      fidx;
  logic [BW-1:0]      bidx;
  logic [3:0]         bit_idx;
  logic [BDW-1:0]     baud;
  logic [FLIT_W-1:0]  flits [MAX_FLITS];

  logic               accept;
  logic [2:0]         typ;
  logic [SEQ_W-1:0]   seq_f;
  logic               head_ok;
  logic               body_fits;
  logic               wr_en;
  logic [FLIT_W-1:0]  shifted;
  logic [7:0]         cur_byte;

  // UART frame bit at position pos: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] pos);
    logic [3:0] pm1;
    pm1 = pos - 4'd1;
    if (pos == 4'd0)      return 1'b0;
    else if (pos >= 4'd9) return 1'b1;
    else                  return b[pm1[2:0]];
  endfunction

  assign flit_ready = rdy;
  assign busy       = (state != IDLE);
  assign accept     = flit_valid && rdy;
  assign typ        = flit_in[FLIT_W-1 -: 3];
  assign seq_f      = flit_in[SEQ_W-1:0];

  // Decode of the incoming flit and the buffer write strobe.
  always_comb begin
    head_ok   = ((typ == T_REG) && (seq_f == reg_seq)) ||
                ((typ == T_PRI) && (seq_f == pri_seq));
    body_fits = (count < CW'(MAX_FLITS - 1));
    wr_en     = 1'b0;
    if (accept) begin
      if (state == IDLE)
        wr_en = head_ok;
      else if (state == COLLECT)
        wr_en = ((typ == T_BODY) && body_fits) || (typ == T_TAIL);
    end
  end

  // Byte currently on the wire, selected most-significant first.
  always_comb begin
    shifted  = flits[fidx] << {bidx, 3'b000};
    cur_byte = shifted[FLIT_W-1 -: 8];
  end

  // Packet buffer; data only, no reset. Count is 0 in IDLE so heads land at 0.
  always_ff @(posedge clk) begin
    if (wr_en)
      flits[count[IW-1:0]] <= flit_in;
  end

  // Control FSM: sequence checking, packet collection and UART serialisation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdy       <= 1'b0;
      txd       <= 1'b1;
      seq_err   <= 1'b0;
      frame_err <= 1'b0;
      reg_seq   <= '0;
      pri_seq   <= '0;
      count     <= '0;
      fidx      <= '0;
      bidx      <= '0;
      bit_idx   <= '0;
      baud      <= '0;
    end else begin
      seq_err   <= 1'b0;
      frame_err <= 1'b0;
      rdy       <= 1'b1;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (accept && (typ == T_REG || typ == T_PRI)) begin
            if (head_ok) begin
              count <= CW'(1);
              state <= COLLECT;
              if (typ == T_REG) reg_seq <= reg_seq + SEQ_W'(1);
              else              pri_seq <= pri_seq + SEQ_W'(1);
            end else begin
              seq_err <= 1'b1;
            end
          end
        end
        COLLECT: begin
          txd <= 1'b1;
          if (accept) begin
            if (typ == T_BODY && body_fits) begin
              count <= count + CW'(1);
            end else if (typ == T_TAIL) begin
              // First start bit goes out on the very next cycle.
              count   <= count + CW'(1);
              state   <= SEND;
              rdy     <= 1'b0;
              txd     <= 1'b0;
              fidx    <= '0;
              bidx    <= '0;
              bit_idx <= '0;
              baud    <= '0;
            end else begin
              frame_err <= 1'b1;
              count     <= '0;
              state     <= IDLE;
            end
          end
        end
        SEND: begin
          rdy <= 1'b0;
          if (baud == BDW'(BAUD_DIV - 1)) begin
            baud <= '0;
            if (bit_idx != 4'd9) begin
              bit_idx <= bit_idx + 4'd1;
              txd     <= frame_bit(cur_byte, bit_idx + 4'd1);
            end else if (bidx != BW'(BYTES - 1)) begin
              bidx    <= bidx + BW'(1);
              bit_idx <= '0;
              txd     <= 1'b0;
            end else if (({1'b0, fidx} + CW'(1)) != count) begin
              fidx    <= fidx + IW'(1);
              bidx    <= '0;
              bit_idx <= '0;
              txd     <= 1'b0;
            end else begin
              // Last stop bit done: line stays idle-high.
              state   <= IDLE;
              rdy     <= 1'b1;
              txd     <= 1'b1;
              count   <= '0;
              fidx    <= '0;
              bidx    <= '0;
              bit_idx <= '0;
            end
          end else begin
            baud <= baud + BDW'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_uart_ni_gen.sv
// Directed bench for router_uart_ni_gen with default parameters.
module tb_router_uart_ni_gen;

  localparam int FLIT_W = 16;
  localparam int BD     = 16;
  localparam int SEQ_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [FLIT_W-1:0] flit_in = '0;
  logic              flit_valid = 1'b0;
  logic              flit_ready;
  logic              txd;
  logic              busy;
  logic              seq_err;
  logic              frame_err;
  logic [SEQ_W-1:0]  reg_seq;
  logic [SEQ_W-1:0]  pri_seq;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_bytes [16];
  int         exp_n;

  router_uart_ni_gen #(.FLIT_W(FLIT_W), .MAX_FLITS(4), .BAUD_DIV(BD), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .txd(txd), .busy(busy), .seq_err(seq_err),
    .frame_err(frame_err), .reg_seq(reg_seq), .pri_seq(pri_seq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Present one flit for exactly one cycle; it must be accepted.
  task automatic send_flit(input logic [FLIT_W-1:0] f);
    flit_in    = f;
    flit_valid = 1'b1;
    checks++;
    if (flit_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready flit=%h got=%b want=1", f, flit_ready);
    end
    step();
    flit_valid = 1'b0;
  endtask

  // Called on the first cycle after the tail accept: checks every cycle of the frame.
  task automatic check_tx(input string name);
    int ncyc, bad_txd, bad_busy, first_k, bitpos, bnum, j;
    logic e;
    ncyc = exp_n * 10 * BD;
    bad_txd = 0;
    bad_busy = 0;
    first_k = -1;
    for (int k = 0; k < ncyc; k++) begin
      bitpos = k / BD;
      bnum   = bitpos / 10;
      j      = bitpos % 10;
      if (j == 0)      e = 1'b0;
      else if (j == 9) e = 1'b1;
      else             e = exp_bytes[bnum][j-1];
      if (txd !== e) begin
        bad_txd++;
        if (first_k < 0) first_k = k;
      end
      if (busy !== 1'b1 || flit_ready !== 1'b0) bad_busy++;
      step();
    end
    checks++;
    if (bad_txd != 0) begin
      failures++;
      $display("FAIL %s_txd bad_cycles=%0d first_at=%0d want 0 bad cycles", name, bad_txd, first_k);
    end
    checks++;
    if (bad_busy != 0) begin
      failures++;
      $display("FAIL %s_busy bad_cycles=%0d want 0 (busy=1 ready=0 for %0d cycles)", name, bad_busy, ncyc);
    end
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1 || flit_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_end busy=%b txd=%b ready=%b want 0 1 1", name, busy, txd, flit_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (flit_ready !== 1'b0 || busy !== 1'b0 || txd !== 1'b1 || seq_err !== 1'b0 ||
        frame_err !== 1'b0 || reg_seq !== 8'h00 || pri_seq !== 8'h00) begin
      failures++;
      $display("FAIL reset_state rdy=%b busy=%b txd=%b se=%b fe=%b rs=%h ps=%h want 0 0 1 0 0 00 00",
               flit_ready, busy, txd, seq_err, frame_err, reg_seq, pri_seq);
    end
    rst = 1'b0;
    step();
    checks++;
    if (flit_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", flit_ready);
    end
  endtask

  task automatic test_regular();
    send_flit(16'h0000);
    checks++;
    if (busy !== 1'b1 || reg_seq !== 8'h01 || txd !== 1'b1 || flit_ready !== 1'b1) begin
      failures++;
      $display("FAIL regular_head busy=%b rs=%h txd=%b rdy=%b want 1 01 1 1", busy, reg_seq, txd, flit_ready);
    end
    send_flit(16'hC0A5);
    exp_bytes[0] = 8'h00; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'hC0; exp_bytes[3] = 8'hA5;
    exp_n = 4;
    check_tx("regular");
  endtask

  task automatic test_priority();
    send_flit(16'h2000);
    send_flit(16'h4123);
    send_flit(16'hC0FF);
    exp_bytes[0] = 8'h20; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h41;
    exp_bytes[3] = 8'h23; exp_bytes[4] = 8'hC0; exp_bytes[5] = 8'hFF;
    exp_n = 6;
    check_tx("priority");
    checks++;
    if (pri_seq !== 8'h01 || reg_seq !== 8'h01) begin
      failures++;
      $display("FAIL priority_seq ps=%h rs=%h want 01 01", pri_seq, reg_seq);
    end
  endtask

  task automatic test_back_to_back();
    // Longest packet, sent on the cycle right after the previous SEND ended.
    send_flit(16'h2001);
    send_flit(16'h4AB1);
    send_flit(16'h4CD2);
    send_flit(16'hC0EE);
    exp_bytes[0] = 8'h20; exp_bytes[1] = 8'h01; exp_bytes[2] = 8'h4A; exp_bytes[3] = 8'hB1;
    exp_bytes[4] = 8'h4C; exp_bytes[5] = 8'hD2; exp_bytes[6] = 8'hC0; exp_bytes[7] = 8'hEE;
    exp_n = 8;
    check_tx("maxpkt");
    checks++;
    if (pri_seq !== 8'h02 || reg_seq !== 8'h01) begin
      failures++;
      $display("FAIL maxpkt_seq ps=%h rs=%h want 02 01", pri_seq, reg_seq);
    end
  endtask

  task automatic test_seq_err();
    do_reset();
    send_flit(16'h0005);
    checks++;
    if (seq_err !== 1'b1 || busy !== 1'b0 || reg_seq !== 8'h00 || txd !== 1'b1) begin
      failures++;
      $display("FAIL seqerr_pulse se=%b busy=%b rs=%h txd=%b want 1 0 00 1", seq_err, busy, reg_seq, txd);
    end
    step();
    checks++;
    if (seq_err !== 1'b0 || txd !== 1'b1) begin
      failures++;
      $display("FAIL seqerr_single se=%b txd=%b want 0 1", seq_err, txd);
    end
    send_flit(16'h2003);
    checks++;
    if (seq_err !== 1'b1 || pri_seq !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL seqerr_pri se=%b ps=%h busy=%b want 1 00 0", seq_err, pri_seq, busy);
    end
    // Stray tail in IDLE is dropped silently.
    send_flit(16'hC000);
    checks++;
    if (seq_err !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_tail se=%b fe=%b busy=%b want 0 0 0", seq_err, frame_err, busy);
    end
  endtask

  task automatic test_frame_err();
    int txd_low;
    txd_low = 0;
    send_flit(16'h0000);
    send_flit(16'h4001);
    send_flit(16'h4002);
    checks++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL frame_body2 fe=%b busy=%b want 0 1", frame_err, busy);
    end
    send_flit(16'h4003);
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0 || reg_seq !== 8'h01) begin
      failures++;
      $display("FAIL frame_overflow fe=%b busy=%b rs=%h want 1 0 01", frame_err, busy, reg_seq);
    end
    for (int k = 0; k < 40; k++) begin
      if (txd !== 1'b1) txd_low++;
      step();
    end
    checks++;
    if (frame_err !== 1'b0 || txd_low != 0) begin
      failures++;
      $display("FAIL frame_quiet fe=%b txd_low_cycles=%0d want 0 0", frame_err, txd_low);
    end
    // Head inside COLLECT aborts; counter keeps only the first head's increment.
    send_flit(16'h0001);
    send_flit(16'h0002);
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0 || reg_seq !== 8'h02) begin
      failures++;
      $display("FAIL frame_head fe=%b busy=%b rs=%h want 1 0 02", frame_err, busy, reg_seq);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int s = 0; s < 255; s++) begin
      send_flit(16'(s));
      send_flit(16'h6000);
    end
    checks++;
    if (reg_seq !== 8'hFF || busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pre rs=%h busy=%b want FF 0", reg_seq, busy);
    end
    send_flit(16'h00FF);
    checks++;
    if (reg_seq !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wrap_seq rs=%h busy=%b want 00 1", reg_seq, busy);
    end
    send_flit(16'hC05A);
    exp_bytes[0] = 8'h00; exp_bytes[1] = 8'hFF; exp_bytes[2] = 8'hC0; exp_bytes[3] = 8'h5A;
    exp_n = 4;
    check_tx("wrap");
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    send_flit(16'h0000);
    send_flit(16'hC0A5);
    repeat (100) step();
    rst = 1'b1;
    step();
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || reg_seq !== 8'h00 || pri_seq !== 8'h00 || flit_ready !== 1'b0) begin
      failures++;
      $display("FAIL midsend_reset txd=%b busy=%b rs=%h ps=%h rdy=%b want 1 0 00 00 0",
               txd, busy, reg_seq, pri_seq, flit_ready);
    end
    rst = 1'b0;
    step();
    send_flit(16'h0000);
    checks++;
    if (reg_seq !== 8'h01 || busy !== 1'b1 || txd !== 1'b1) begin
      failures++;
      $display("FAIL midsend_after rs=%h busy=%b txd=%b want 01 1 1", reg_seq, busy, txd);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_regular();
    test_priority();
    test_back_to_back();
    test_seq_err();
    test_frame_err();
    test_wrap();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
